// File: rtl/exe_stage_pkg.sv
// Shared op-card encodings and result record for the execute stage and the ALU.
// The ALU reuses these constants, so there is a single definition of each op code.
package exe_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;

  typedef enum logic [FUNCT_W-1:0] {
    OP_SLL  = 6'b000000,
    OP_MOVZ = 6'b001010,
    OP_ADD  = 6'b100000,
    OP_SUB  = 6'b100010,
    OP_AND  = 6'b100100,
    OP_OR   = 6'b100101,
    OP_XOR  = 6'b100110,
    OP_CMP  = 6'b111110
  } op_card_e;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  waddr;
    logic              wen;
    logic              illegal;
  } result_t;

  function automatic logic is_legal(input logic [FUNCT_W-1:0] funct);
    case (funct)
      OP_SLL, OP_MOVZ, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_CMP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Decode-side, ALU-side and writeback-side signals of the execute stage.
// The stage itself uses the slave modport; the surrounding datapath uses master.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [FUNCT_W-1:0]  in_funct;
  logic [SHAMT_W-1:0]  in_shamt;
  logic [DATA_W-1:0]   in_rs_val;
  logic [DATA_W-1:0]   in_rt_val;
  logic [REG_W-1:0]    in_rd;

  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [FUNCT_W-1:0]  alu_card;
  logic [SHAMT_W-1:0]  alu_shft;
  logic [DATA_W-1:0]   alu_f;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_wdata;
  logic [REG_W-1:0]    out_waddr;
  logic                out_wen;
  logic                out_illegal;
  logic [DATA_W-1:0]   retire_cnt;

  modport slave (
    input  in_valid, in_funct, in_shamt, in_rs_val, in_rt_val, in_rd,
    input  alu_f, out_ready,
    output in_ready, alu_a, alu_b, alu_card, alu_shft,
    output out_valid, out_wdata, out_waddr, out_wen, out_illegal, retire_cnt
  );

  modport master (
    output in_valid, in_funct, in_shamt, in_rs_val, in_rt_val, in_rd,
    output alu_f, out_ready,
    input  in_ready, alu_a, alu_b, alu_card, alu_shft,
    input  out_valid, out_wdata, out_waddr, out_wen, out_illegal, retire_cnt
  );

endinterface

// File: rtl/exe_decode.sv
// Combinational decode of the operand-register contents: ALU op card,
// illegal-funct flag and register write enable.
module exe_decode
  import exe_stage_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  input  logic [REG_W-1:0]   rd,
  input  logic [DATA_W-1:0]  b,
  output logic [FUNCT_W-1:0] card,
  output logic               illegal,
  output logic               wen
);

  always_comb begin
    illegal = !is_legal(funct);
    // Unknown codes still need a defined ALU operation; ADD is harmless since wen is forced low.
    card    = illegal ? OP_ADD : funct;
    wen     = 1'b1;
    if (illegal || rd == '0)
      wen = 1'b0;
    else if (funct == OP_MOVZ)
      wen = (b == '0);
  end

endmodule

// File: rtl/exe_stage.sv
// Two-deep execute stage: operand register feeding the external ALU, then a
// result register offered to writeback. Full throughput, 2-cycle latency.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  exe_stage_if.slave  bus
);

  logic                      vld_p1;
  logic [FUNCT_W-1:0]        funct_p1;
  logic [SHAMT_W-1:0]        shamt_p1;
  logic signed [DATA_W-1:0]  a_p1;
  logic signed [DATA_W-1:0]  b_p1;
  logic [REG_W-1:0]          rd_p1;

  logic                      vld_p2;
  result_t                   res_p2;
  logic [DATA_W-1:0]         retire_cnt_q;

  logic                      s2_free;
  logic                      advance;
  logic                      in_ready_w;
  logic                      accept;
  logic                      drain;

  logic [FUNCT_W-1:0]        card_p1;
  logic                      illegal_p1;
  logic                      wen_p1;

  assign s2_free    = !vld_p2 || bus.out_ready;
  assign advance    = vld_p1 && s2_free;
  assign in_ready_w = !vld_p1 || s2_free;
  assign accept     = bus.in_valid && in_ready_w;
  assign drain      = vld_p2 && bus.out_ready;

  exe_decode u_decode (
    .funct   (funct_p1),
    .rd      (rd_p1),
    .b       (b_p1),
    .card    (card_p1),
    .illegal (illegal_p1),
    .wen     (wen_p1)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1       <= 1'b0;
      funct_p1     <= '0;
      shamt_p1     <= '0;
      a_p1         <= '0;
      b_p1         <= '0;
      rd_p1        <= '0;
      vld_p2       <= 1'b0;
      res_p2       <= '0;
      retire_cnt_q <= '0;
    end else begin
      // p0 -> p1: latch decode-stage operands on accept
      if (accept) begin
        vld_p1   <= 1'b1;
        funct_p1 <= bus.in_funct;
        shamt_p1 <= bus.in_shamt;
        a_p1     <= bus.in_rs_val;
        b_p1     <= bus.in_rt_val;
        rd_p1    <= bus.in_rd;
      end else if (advance) begin
        vld_p1   <= 1'b0;
      end

      // p1 -> p2: capture ALU result; an empty p1 simply clears p2 when it drains
      if (s2_free)
        vld_p2 <= vld_p1;
      if (advance)
        res_p2 <= '{wdata: bus.alu_f, waddr: rd_p1, wen: wen_p1, illegal: illegal_p1};

      if (drain)
        retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.alu_a       = a_p1;
  assign bus.alu_b       = b_p1;
  assign bus.alu_card    = card_p1;
  assign bus.alu_shft    = shamt_p1;
  assign bus.out_valid   = vld_p2;
  assign bus.out_wdata   = res_p2.wdata;
  assign bus.out_waddr   = res_p2.waddr;
  assign bus.out_wen     = res_p2.wen;
  assign bus.out_illegal = res_p2.illegal;
  assign bus.retire_cnt  = retire_cnt_q;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute-stage wrapper that sits directly upstream of the combinational ALU in the lab CPU datapath. It accepts decoded R-type operations from the decode stage over a valid/ready handshake and latches them in an operand register that drives the ALU. It captures the ALU result in a result register and offers it to writeback over a second valid/ready handshake. It is a two-deep pipeline: full throughput, fixed 2-cycle latency when unstalled.

## Interface
Parameters:
- none (datapath fixed at 32 bits; register address 5 bits)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  decode stage offers an operation
- in_ready  out  1  stage accepts the operation this cycle
- in_funct  in  6  function code; equals ALU op-card encoding
- in_shamt  in  5  shift amount
- in_rs_val  in  32  operand A value
- in_rt_val  in  32  operand B value
- in_rd  in  5  destination register
- alu_a  out  32  to ALU input A
- alu_b  out  32  to ALU input B
- alu_card  out  6  to ALU op card
- alu_shft  out  5  to ALU shift input
- alu_f  in  32  ALU result (combinational from alu_* outputs)
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts the result
- out_wdata  out  32  result value
- out_waddr  out  5  destination register
- out_wen  out  1  register write enable
- out_illegal  out  1  unrecognised funct
- retire_cnt  out  32  count of results accepted downstream

## Operation
- Legal funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 001010 MOVZ, 000000 SLL, 111110 CMP. Any other value is illegal.
- S1 (operand register): s1_valid, funct, shamt, A, B, rd, illegal flag. It drives alu_a=A, alu_b=B, alu_shft=shamt, and alu_card=funct (ADD when illegal).
- S2 (result register): s2_valid, wdata=alu_f, waddr=rd, wen, illegal. All are captured from S1 when S1 advances.
- wen rules, computed at S1→S2: wen=0 if illegal or rd==0. For MOVZ, wen=1 only if B==0. Otherwise wen=1.
- Handshake:
  - s2_free = !s2_valid || out_ready
  - s1 advances when s1_valid && s2_free
  - in_ready = !s1_valid || s2_free
  - Accept on in_valid && in_ready.
- out_valid = s2_valid. While out_valid=1 and out_ready=0, S2 contents hold stable.
- If S1 is empty when S2 drains, s2_valid clears.
- retire_cnt increments on each out_valid && out_ready, and wraps from 0xFFFFFFFF to 0.
- Illegal operations still flow through and are delivered with out_illegal=1 and wen=0. They do not stall the stage.

## Timing
- Reset (resetn=0 at an edge):
  - s1_valid=0 and s2_valid=0; all data registers and retire_cnt return to 0.
  - Outputs: in_ready=1, out_valid=0, out_wen=0, out_illegal=0, alu_a/alu_b/alu_shft=0, alu_card=000000.
  - In-flight operations are discarded. Reset mid-stall drops both stages.
- Latency: an operation accepted at edge N is visible with out_valid=1 after edge N+1 when out_ready is high. Sustained throughput is 1 per cycle.
- in_ready depends combinationally on out_ready; no other combinational input-to-output paths except alu_f→S2 capture.
- Simultaneous events: a new accept into S1, S1→S2 advance, and S2 drain can all occur on the same edge.
- Full: both stages valid and out_ready=0 gives in_ready=0.
- Empty: both stages invalid gives out_valid=0 and in_ready=1.
- in_* inputs are sampled only on accept. Changes while in_ready=0 are ignored.

## Structure
- Shared include/package holds the eight funct/op-card constants. The ALU's op-code defines move there so both blocks share a single definition.
- One natural sub-module: exe_decode (combinational). Inputs: funct, rd, B. Outputs: card, illegal, wen.
- The ALU itself stays external; the integration top connects alu_* ↔ ALU ports.

## Test plan
- ADD, A=5, B=7, rd=3, out_ready=1 → two edges later: out_valid=1, out_wdata=12, out_waddr=3, out_wen=1; retire_cnt=1 after accept.
- Back-to-back SUB (10−3), SLL (B=1, shamt=4), CMP (A=1, B=2) with out_ready=1 → results 7, 16, 0x0000014E on consecutive cycles; in_ready stays 1.
- MOVZ A=0xAA with B=0, then B=1 (rd=4) → wen=1 with wdata=0xAA, then wen=0.
- Backpressure: out_ready=0 for 3 cycles while 3 ops offered → in_ready=0 after 2 accepted, S2 data stable, no loss. Releasing gives in-order delivery.
- funct=111111 → delivered with out_illegal=1 and out_wen=0. rd=0 ADD → out_wen=0.
- resetn=0 with both stages full → next cycle out_valid=0, in_ready=1, retire_cnt=0; dropped ops never appear.
